// File: rtl/smart_door_if.sv
// Signal bundle linking the mat/sensor front end, the door controller and the motor driver.
`timescale 1ns/1ps
interface smart_door_if #(
   parameter int OCC_W = 5
);
   logic             pressure_in;
   logic             pressure_out;
   logic             obstruct;
   logic             store_open;
   logic             motor_open;
   logic             motor_close;
   logic             door_open;
   logic [OCC_W-1:0] occupancy;
   logic             full;
   logic             entry_denied;

   modport master (
      output pressure_in, pressure_out, obstruct, store_open,
      input  motor_open, motor_close, door_open, occupancy, full, entry_denied
   );

   modport slave (
      input  pressure_in, pressure_out, obstruct, store_open,
      output motor_open, motor_close, door_open, occupancy, full, entry_denied
   );
endinterface

// File: rtl/smart_door_ctrl.sv
// Automatic entrance door sequencer: CLOSED/OPENING/OPEN/CLOSING with occupancy tracking
// and capacity-based entry refusal.
`timescale 1ns/1ps
module smart_door_ctrl #(
   parameter int TRAVEL_CYC = 4,
   parameter int HOLD_CYC   = 10,
   parameter int MAX_OCC    = 20,
   parameter int OCC_W      = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   smart_door_if.slave bus
);
   localparam int CNT_MAX = (TRAVEL_CYC > HOLD_CYC) ? TRAVEL_CYC : HOLD_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(MAX_OCC);

   typedef enum logic [1:0] {S_CLOSED, S_OPENING, S_OPEN, S_CLOSING} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pin_q, pout_q;
   logic             motor_open_q, motor_close_q, door_open_q, denied_q;

   logic full, req_in, req_out, rise_in, fall_in, fall_out, activity;

   assign full     = (occ_q == OCC_MAX);
   assign req_in   = bus.pressure_in & bus.store_open & ~full;
   assign req_out  = bus.pressure_out;
   assign rise_in  = bus.pressure_in & ~pin_q;
   assign fall_in  = ~bus.pressure_in & pin_q;
   assign fall_out = ~bus.pressure_out & pout_q;
   // Raw pressure_in keeps the door held even when entry is refused, so nobody is trapped.
   assign activity = bus.pressure_in | bus.pressure_out | bus.obstruct;

   always_comb begin
      occ_d = occ_q;
      if (state_q == S_OPEN) begin
         if (fall_in && !fall_out && !full)
            occ_d = occ_q + 1'b1;
         else if (fall_out && !fall_in && (occ_q != '0))
            occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_CLOSED;
         cnt_q         <= '0;
         occ_q         <= '0;
         pin_q         <= 1'b0;
         pout_q        <= 1'b0;
         motor_open_q  <= 1'b0;
         motor_close_q <= 1'b0;
         door_open_q   <= 1'b0;
         denied_q      <= 1'b0;
      end else begin
         pin_q    <= bus.pressure_in;
         pout_q   <= bus.pressure_out;
         occ_q    <= occ_d;
         denied_q <= rise_in & (full | ~bus.store_open);
         case (state_q)
            S_CLOSED: begin
               if (req_in || req_out) begin
                  state_q      <= S_OPENING;
                  cnt_q        <= TRAVEL_LD;
                  motor_open_q <= 1'b1;
               end
            end
            S_OPENING: begin
               if (cnt_q == '0) begin
                  state_q      <= S_OPEN;
                  cnt_q        <= HOLD_LD;
                  motor_open_q <= 1'b0;
                  door_open_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_OPEN: begin
               if (activity) begin
                  cnt_q <= HOLD_LD;
               end else if (cnt_q == '0) begin
                  state_q       <= S_CLOSING;
                  cnt_q         <= TRAVEL_LD;
                  door_open_q   <= 1'b0;
                  motor_close_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_CLOSING: begin
               // Reversal wins over stroke completion in the same cycle.
               if (bus.obstruct || req_in || req_out) begin
                  state_q       <= S_OPENING;
                  cnt_q         <= TRAVEL_LD;
                  motor_close_q <= 1'b0;
                  motor_open_q  <= 1'b1;
               end else if (cnt_q == '0) begin
                  state_q       <= S_CLOSED;
                  motor_close_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q       <= S_CLOSED;
               motor_open_q  <= 1'b0;
               motor_close_q <= 1'b0;
               door_open_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.motor_open   = motor_open_q;
   assign bus.motor_close  = motor_close_q;
   assign bus.door_open    = door_open_q;
   assign bus.occupancy    = occ_q;
   assign bus.full         = full;
   assign bus.entry_denied = denied_q;
endmodule
